// File: rtl/writeback_forward_unit_pkg.sv
// Shared constants, writeback stage entry type and read-port naming for the
// SPU-lite writeback/forwarding slice.
package writeback_forward_unit_pkg;

    localparam int unsigned WIDTH        = 128;
    localparam int unsigned SIZE         = 128;
    localparam int unsigned LOGSIZE      = $clog2(SIZE);
    localparam int unsigned WB_DEPTH     = 7;
    localparam int unsigned NUM_RD_PORTS = 6;

    typedef enum logic [2:0] {
        RA_EVEN,
        RA_ODD,
        RB_EVEN,
        RB_ODD,
        RC_EVEN,
        RC_ODD
    } rd_port_e;

    typedef struct packed {
        logic               valid;
        logic [0:LOGSIZE-1] addr;
        logic [0:WIDTH-1]   data;
    } wb_entry_t;

    function automatic logic entry_hit(input wb_entry_t e, input logic [0:LOGSIZE-1] a);
        return e.valid && (e.addr == a);
    endfunction

endpackage

// File: rtl/writeback_forward_unit_if.sv
// Bundle of result inputs, operand read ports and register file write ports
// shared by execute, issue and the register file around the writeback unit.
interface writeback_forward_unit_if;
    import writeback_forward_unit_pkg::*;

    logic               even_res_valid;
    logic [0:LOGSIZE-1] even_res_addr;
    logic [0:WIDTH-1]   even_res_data;
    logic               odd_res_valid;
    logic [0:LOGSIZE-1] odd_res_addr;
    logic [0:WIDTH-1]   odd_res_data;

    logic [0:LOGSIZE-1] ra_even_addr_in;
    logic [0:LOGSIZE-1] ra_odd_addr_in;
    logic [0:LOGSIZE-1] rb_even_addr_in;
    logic [0:LOGSIZE-1] rb_odd_addr_in;
    logic [0:LOGSIZE-1] rc_even_addr_in;
    logic [0:LOGSIZE-1] rc_odd_addr_in;

    logic [0:WIDTH-1]   ra_even_rf_data;
    logic [0:WIDTH-1]   ra_odd_rf_data;
    logic [0:WIDTH-1]   rb_even_rf_data;
    logic [0:WIDTH-1]   rb_odd_rf_data;
    logic [0:WIDTH-1]   rc_even_rf_data;
    logic [0:WIDTH-1]   rc_odd_rf_data;

    logic [0:WIDTH-1]   ra_even_fwd_data;
    logic [0:WIDTH-1]   ra_odd_fwd_data;
    logic [0:WIDTH-1]   rb_even_fwd_data;
    logic [0:WIDTH-1]   rb_odd_fwd_data;
    logic [0:WIDTH-1]   rc_even_fwd_data;
    logic [0:WIDTH-1]   rc_odd_fwd_data;

    logic [0:LOGSIZE-1] rt_even_addr_out;
    logic [0:WIDTH-1]   rt_even_data_out;
    logic [0:LOGSIZE-1] rt_odd_addr_out;
    logic [0:WIDTH-1]   rt_odd_data_out;
    logic               wr_en_even;
    logic               wr_en_odd;
    logic               collision_err;

    modport master (
        output even_res_valid, even_res_addr, even_res_data,
        output odd_res_valid, odd_res_addr, odd_res_data,
        output ra_even_addr_in, ra_odd_addr_in, rb_even_addr_in,
        output rb_odd_addr_in, rc_even_addr_in, rc_odd_addr_in,
        output ra_even_rf_data, ra_odd_rf_data, rb_even_rf_data,
        output rb_odd_rf_data, rc_even_rf_data, rc_odd_rf_data,
        input  ra_even_fwd_data, ra_odd_fwd_data, rb_even_fwd_data,
        input  rb_odd_fwd_data, rc_even_fwd_data, rc_odd_fwd_data,
        input  rt_even_addr_out, rt_even_data_out,
        input  rt_odd_addr_out, rt_odd_data_out,
        input  wr_en_even, wr_en_odd, collision_err
    );

    modport slave (
        input  even_res_valid, even_res_addr, even_res_data,
        input  odd_res_valid, odd_res_addr, odd_res_data,
        input  ra_even_addr_in, ra_odd_addr_in, rb_even_addr_in,
        input  rb_odd_addr_in, rc_even_addr_in, rc_odd_addr_in,
        input  ra_even_rf_data, ra_odd_rf_data, rb_even_rf_data,
        input  rb_odd_rf_data, rc_even_rf_data, rc_odd_rf_data,
        output ra_even_fwd_data, ra_odd_fwd_data, rb_even_fwd_data,
        output rb_odd_fwd_data, rc_even_fwd_data, rc_odd_fwd_data,
        output rt_even_addr_out, rt_even_data_out,
        output rt_odd_addr_out, rt_odd_data_out,
        output wr_en_even, wr_en_odd, collision_err
    );

endinterface

// File: rtl/writeback_forward_unit_pipe.sv
// One side's DEPTH-stage writeback pipe; every stage is exposed so the top
// level can forward from any in-flight result.
module wb_result_pipe
    import writeback_forward_unit_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  res_valid,
    input  logic [0:LOGSIZE-1]    res_addr,
    input  logic [0:WIDTH-1]      res_data,
    output wb_entry_t [DEPTH-1:0] stages
);

    wb_entry_t [DEPTH-1:0] stage_q;

    assign stages = stage_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else if (stall) begin
            // A flush under stall still squashes younger work; the final stage
            // keeps its result so it can commit once the stall lifts.
            if (flush) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    stage_q[i].valid <= 1'b0;
                end
            end
        end else begin
            stage_q[0].valid <= res_valid;
            stage_q[0].addr  <= res_addr;
            stage_q[0].data  <= res_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            if (flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_forward_unit.sv
// Even/odd writeback pipes feeding the register file write ports, with
// youngest-first forwarding of in-flight results to all six operand ports.
module writeback_forward_unit
    import writeback_forward_unit_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    writeback_forward_unit_if.slave  bus
);

    wb_entry_t [DEPTH-1:0] even_s;
    wb_entry_t [DEPTH-1:0] odd_s;
    wb_entry_t             even_tail;
    wb_entry_t             odd_tail;
    logic                  collision;
    logic                  collision_err_q;

    logic [0:LOGSIZE-1] rd_addr [NUM_RD_PORTS];
    logic [0:WIDTH-1]   rd_rf   [NUM_RD_PORTS];
    logic [0:WIDTH-1]   rd_fwd  [NUM_RD_PORTS];

    wb_result_pipe #(.DEPTH(DEPTH)) u_even_pipe (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .res_valid (bus.even_res_valid),
        .res_addr  (bus.even_res_addr),
        .res_data  (bus.even_res_data),
        .stages    (even_s)
    );

    wb_result_pipe #(.DEPTH(DEPTH)) u_odd_pipe (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .res_valid (bus.odd_res_valid),
        .res_addr  (bus.odd_res_addr),
        .res_data  (bus.odd_res_data),
        .stages    (odd_s)
    );

    assign even_tail = even_s[DEPTH-1];
    assign odd_tail  = odd_s[DEPTH-1];

    // Same-address commits from both sides in one cycle: odd wins the write.
    assign collision = !stall && even_tail.valid && odd_tail.valid &&
                       (even_tail.addr == odd_tail.addr);

    assign bus.wr_en_even       = even_tail.valid && !stall && !collision;
    assign bus.wr_en_odd        = odd_tail.valid && !stall;
    assign bus.rt_even_addr_out = even_tail.addr;
    assign bus.rt_even_data_out = even_tail.data;
    assign bus.rt_odd_addr_out  = odd_tail.addr;
    assign bus.rt_odd_data_out  = odd_tail.data;
    assign bus.collision_err    = collision_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_err_q <= 1'b0;
        end else if (collision) begin
            collision_err_q <= 1'b1;
        end
    end

    assign rd_addr[RA_EVEN] = bus.ra_even_addr_in;
    assign rd_addr[RA_ODD]  = bus.ra_odd_addr_in;
    assign rd_addr[RB_EVEN] = bus.rb_even_addr_in;
    assign rd_addr[RB_ODD]  = bus.rb_odd_addr_in;
    assign rd_addr[RC_EVEN] = bus.rc_even_addr_in;
    assign rd_addr[RC_ODD]  = bus.rc_odd_addr_in;

    assign rd_rf[RA_EVEN] = bus.ra_even_rf_data;
    assign rd_rf[RA_ODD]  = bus.ra_odd_rf_data;
    assign rd_rf[RB_EVEN] = bus.rb_even_rf_data;
    assign rd_rf[RB_ODD]  = bus.rb_odd_rf_data;
    assign rd_rf[RC_EVEN] = bus.rc_even_rf_data;
    assign rd_rf[RC_ODD]  = bus.rc_odd_rf_data;

    // Walk oldest to youngest so later hits override: youngest stage wins,
    // and within a stage the odd check runs last so odd wins.
    always_comb begin
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            rd_fwd[p] = rd_rf[p];
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (entry_hit(even_s[DEPTH-1-k], rd_addr[p])) begin
                    rd_fwd[p] = even_s[DEPTH-1-k].data;
                end
                if (entry_hit(odd_s[DEPTH-1-k], rd_addr[p])) begin
                    rd_fwd[p] = odd_s[DEPTH-1-k].data;
                end
            end
        end
    end

    assign bus.ra_even_fwd_data = rd_fwd[RA_EVEN];
    assign bus.ra_odd_fwd_data  = rd_fwd[RA_ODD];
    assign bus.rb_even_fwd_data = rd_fwd[RB_EVEN];
    assign bus.rb_odd_fwd_data  = rd_fwd[RB_ODD];
    assign bus.rc_even_fwd_data = rd_fwd[RC_EVEN];
    assign bus.rc_odd_fwd_data  = rd_fwd[RC_ODD];

endmodule

// File: tb/tb_writeback_forward_unit.sv
// Scoreboard bench for writeback_forward_unit: directed results, expected
// commits queued per side and popped by a monitor on every write enable.
module tb_writeback_forward_unit;
    import writeback_forward_unit_pkg::*;

    typedef struct {
        logic [LOGSIZE-1:0] addr;
        logic [WIDTH-1:0]   data;
    } exp_t;

    logic clk = 1'b0;
    logic reset, stall, flush;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_even[$];
    exp_t q_odd[$];
    exp_t mon_e;

    writeback_forward_unit_if ifc();

    writeback_forward_unit #(.DEPTH(7)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pat(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [WIDTH-1:0] rf_val(input int p);
        return pat(8'(8'hC0 + p));
    endfunction

    function automatic logic [WIDTH-1:0] fwd(input int p);
        case (p)
            0:       return ifc.ra_even_fwd_data;
            1:       return ifc.ra_odd_fwd_data;
            2:       return ifc.rb_even_fwd_data;
            3:       return ifc.rb_odd_fwd_data;
            4:       return ifc.rc_even_fwd_data;
            default: return ifc.rc_odd_fwd_data;
        endcase
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_fwd_all(input string name, input logic [WIDTH-1:0] exp);
        for (int p = 0; p < 6; p++) chk($sformatf("%s_p%0d", name, p), fwd(p), exp);
    endtask

    task automatic chk_fwd_rf(input string name);
        for (int p = 0; p < 6; p++) chk($sformatf("%s_p%0d", name, p), fwd(p), rf_val(p));
    endtask

    task automatic set_rd(input logic [LOGSIZE-1:0] a);
        ifc.ra_even_addr_in = a; ifc.ra_odd_addr_in = a;
        ifc.rb_even_addr_in = a; ifc.rb_odd_addr_in = a;
        ifc.rc_even_addr_in = a; ifc.rc_odd_addr_in = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one result pair for exactly one edge; 'ec'/'oc' say whether it should commit.
    task automatic issue(input logic ev, input logic [LOGSIZE-1:0] ea, input logic [WIDTH-1:0] ed, input bit ec,
                         input logic ov, input logic [LOGSIZE-1:0] oa, input logic [WIDTH-1:0] od, input bit oc);
        exp_t e;
        ifc.even_res_valid = ev; ifc.even_res_addr = ea; ifc.even_res_data = ed;
        ifc.odd_res_valid  = ov; ifc.odd_res_addr  = oa; ifc.odd_res_data  = od;
        if (ev && ec) begin e.addr = ea; e.data = ed; q_even.push_back(e); end
        if (ov && oc) begin e.addr = oa; e.data = od; q_odd.push_back(e); end
        tick();
        ifc.even_res_valid = 1'b0;
        ifc.odd_res_valid  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ifc.wr_en_even === 1'b1) begin
            if (q_even.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL even_unexpected_commit: got write to r%0d, expected no write", ifc.rt_even_addr_out);
            end else begin
                mon_e = q_even.pop_front();
                chk("even_commit_addr", ifc.rt_even_addr_out, mon_e.addr);
                chk("even_commit_data", ifc.rt_even_data_out, mon_e.data);
            end
        end
        if (ifc.wr_en_odd === 1'b1) begin
            if (q_odd.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL odd_unexpected_commit: got write to r%0d, expected no write", ifc.rt_odd_addr_out);
            end else begin
                mon_e = q_odd.pop_front();
                chk("odd_commit_addr", ifc.rt_odd_addr_out, mon_e.addr);
                chk("odd_commit_data", ifc.rt_odd_data_out, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        ifc.even_res_valid = 1'b0; ifc.even_res_addr = '0; ifc.even_res_data = '0;
        ifc.odd_res_valid  = 1'b0; ifc.odd_res_addr  = '0; ifc.odd_res_data  = '0;
        ifc.ra_even_rf_data = rf_val(0); ifc.ra_odd_rf_data = rf_val(1);
        ifc.rb_even_rf_data = rf_val(2); ifc.rb_odd_rf_data = rf_val(3);
        ifc.rc_even_rf_data = rf_val(4); ifc.rc_odd_rf_data = rf_val(5);
        set_rd(0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en_even", ifc.wr_en_even, 0);
        chk("rst_wr_en_odd", ifc.wr_en_odd, 0);
        chk("rst_rt_even_addr", ifc.rt_even_addr_out, 0);
        chk("rst_rt_even_data", ifc.rt_even_data_out, 0);
        chk("rst_rt_odd_addr", ifc.rt_odd_addr_out, 0);
        chk("rst_rt_odd_data", ifc.rt_odd_data_out, 0);
        chk("rst_collision_err", ifc.collision_err, 0);
        chk_fwd_rf("rst_fwd");
        tick();
        reset = 1'b0;

        // Latency and forwarding window of a single even result
        set_rd(5);
        issue(1'b1, 7'd5, pat(8'hAA), 1'b1, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("lat_fwd_k%0d", k), ifc.ra_even_fwd_data, pat(8'hAA));
            chk($sformatf("lat_wr_en_k%0d", k), ifc.wr_en_even, (k == 6));
            if (k == 6) chk("lat_rt_addr", ifc.rt_even_addr_out, 5);
            tick();
        end
        @(negedge clk);
        chk("lat_fwd_after_commit", ifc.ra_even_fwd_data, rf_val(0));
        repeat (3) tick();

        // Younger odd result overrides older even result on all ports
        set_rd(9);
        issue(1'b1, 7'd9, pat(8'h01), 1'b1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk_fwd_all("r9_even", pat(8'h01));
        issue(1'b0, '0, '0, 1'b0, 1'b1, 7'd9, pat(8'h02), 1'b1);
        @(negedge clk);
        chk_fwd_all("r9_odd_younger", pat(8'h02));
        repeat (10) tick();

        // Stall edges 3..5 delay three commits to edges 10..12
        set_rd(20);
        issue(1'b1, 7'd20, pat(8'h20), 1'b1, 1'b0, '0, '0, 1'b0);
        issue(1'b1, 7'd21, pat(8'h21), 1'b1, 1'b0, '0, '0, 1'b0);
        issue(1'b1, 7'd22, pat(8'h22), 1'b1, 1'b0, '0, '0, 1'b0);
        stall = 1'b1;
        for (int e = 3; e <= 12; e++) begin
            tick();
            if (e == 5) stall = 1'b0;
            @(negedge clk);
            chk($sformatf("stall_wr_en_e%0d", e), ifc.wr_en_even, (e >= 9 && e <= 11));
            if (e <= 4) chk($sformatf("stall_fwd_held_e%0d", e), ifc.ra_even_fwd_data, pat(8'h20));
        end
        repeat (3) tick();

        // Stall during a commit cycle suppresses and defers the write
        set_rd(30);
        issue(1'b1, 7'd30, pat(8'h30), 1'b1, 1'b0, '0, '0, 1'b0);
        repeat (6) tick();
        stall = 1'b1;
        @(negedge clk);
        chk("stall_blocks_commit", ifc.wr_en_even, 0);
        chk("stall_fwd_tail", ifc.rc_odd_fwd_data, pat(8'h30));
        tick();
        stall = 1'b0;
        @(negedge clk);
        chk("commit_after_stall", ifc.wr_en_even, 1);
        tick();
        @(negedge clk);
        chk("no_repeat_commit", ifc.wr_en_even, 0);
        repeat (3) tick();

        // Flush while r1 sits in the final stage: only r1 commits
        set_rd(2);
        for (int i = 1; i <= 7; i++)
            issue(1'b1, 7'(i), pat(8'(8'h40 + i)), (i == 1), 1'b0, '0, '0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_final_commits", ifc.wr_en_even, 1);
        chk("flush_commit_addr", ifc.rt_even_addr_out, 1);
        chk_fwd_all("flush_fwd_before_edge", pat(8'h42));
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk_fwd_rf("flush_fwd_r2");
        repeat (10) tick();

        // Even/odd collision on r3: odd forwards and commits, error sticks
        set_rd(3);
        issue(1'b1, 7'd3, pat(8'h33), 1'b0, 1'b1, 7'd3, pat(8'h44), 1'b1);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) chk_fwd_all("same_stage_odd_wins", pat(8'h44));
            if (k == 6) begin
                chk("coll_wr_en_even", ifc.wr_en_even, 0);
                chk("coll_wr_en_odd", ifc.wr_en_odd, 1);
                chk("coll_err_before_edge", ifc.collision_err, 0);
            end else begin
                chk($sformatf("coll_wr_en_odd_k%0d", k), ifc.wr_en_odd, 0);
            end
            tick();
        end
        @(negedge clk);
        chk("collision_err_set", ifc.collision_err, 1);
        repeat (5) tick();
        @(negedge clk);
        chk("collision_err_sticky", ifc.collision_err, 1);

        // Reset with three results in flight: nothing commits
        set_rd(10);
        issue(1'b1, 7'd10, pat(8'h50), 1'b0, 1'b0, '0, '0, 1'b0);
        issue(1'b1, 7'd11, pat(8'h51), 1'b0, 1'b0, '0, '0, 1'b0);
        issue(1'b1, 7'd12, pat(8'h52), 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk_fwd_all("inflight_r10", pat(8'h50));
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_wr_en_even", ifc.wr_en_even, 0);
        chk("midrst_wr_en_odd", ifc.wr_en_odd, 0);
        chk("midrst_rt_even_addr", ifc.rt_even_addr_out, 0);
        chk("midrst_rt_even_data", ifc.rt_even_data_out, 0);
        chk("midrst_collision_err", ifc.collision_err, 0);
        chk_fwd_rf("midrst_fwd");
        tick();
        reset = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk_fwd_rf("after_reset_fwd");

        chk("q_even_drained", q_even.size(), 0);
        chk("q_odd_drained", q_odd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
